btn_debounce: RTL and testbench

- Input-conditioning stage that sits directly upstream of the board top-level's debug-hardware bundle.
- Takes the raw, bouncy, asynchronous push-button pins and produces clean per-button signals for the debug logic that drives the LEDs and bits:
  - synchronised, debounced levels;
  - one-cycle press and release strobes;
  - long-press indications.
- Each button channel is independent; the channel count is parameterised.

---
 rtl/btn_debounce.sv | 148 ++++++++++++++
 tb/tb_btn_debounce.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop sync, per-channel debounce, press/release/long-press strobes.
// Latency: level and strobes DEBOUNCE_CYCLES+1 edges after a stable raw sample; btn_long LONG_CYCLES after btn_press.
// Backpressure: none; free-running, every output is registered and meaningful on every cycle.
module btn_debounce #(
  parameter int N_BTN           = 2,
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int LONG_CYCLES     = 24000000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_long,
  output logic [N_BTN-1:0] btn_long_held
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int LW = $clog2(LONG_CYCLES);
  localparam logic [DW-1:0] DB_MAX   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LW-1:0] HOLD_MAX = LW'(LONG_CYCLES - 1);
  // Raw pin value meaning "released"; XOR with it turns the pin into pressed=1.
  localparam logic POL = (ACTIVE_LOW != 0);

  typedef enum logic [1:0] {
    REL   = 2'd0,
    PRESS = 2'd1,
    LONG  = 2'd2
  } state_t;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic [1:0]    sync_q;
    logic          pressed;
    logic [DW-1:0] db_cnt_q;
    logic          level_q;
    logic          press_q;
    logic          release_q;
    logic          acc_press;
    logic          acc_release;
    state_t        state_q;
    state_t        state_d;
    logic [LW-1:0] hold_q;
    logic [LW-1:0] hold_d;
    logic          long_q;
    logic          long_d;
    logic          held_q;
    logic          held_d;

    // Two-flop synchroniser; starts at the released pin value so a button
    // held through reset is still seen as a fresh press.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q <= {2{POL}};
      end else begin
        sync_q <= {sync_q[0], btn_raw[i]};
      end
    end

    assign pressed     = sync_q[1] ^ POL;
    // A level change is accepted on the edge where the disagreement has
    // already lasted DEBOUNCE_CYCLES-1 edges and is still present.
    assign acc_press   = pressed & ~level_q & (db_cnt_q == DB_MAX);
    assign acc_release = ~pressed & level_q & (db_cnt_q == DB_MAX);

    // Debounce counter: counts consecutive disagreeing edges, any agreement restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        db_cnt_q  <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        press_q   <= acc_press;
        release_q <= acc_release;
        if (pressed == level_q) begin
          db_cnt_q <= '0;
        end else if (db_cnt_q == DB_MAX) begin
          level_q  <= pressed;
          db_cnt_q <= '0;
        end else begin
          db_cnt_q <= db_cnt_q + DW'(1);
        end
      end
    end

    // Press-tracking state, hold counter and long-press flags.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= REL;
        hold_q  <= '0;
        long_q  <= 1'b0;
        held_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        hold_q  <= hold_d;
        long_q  <= long_d;
        held_q  <= held_d;
      end
    end

    // Next state: a release always wins over reaching the long threshold,
    // so btn_long and btn_release can never coincide.
    always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      long_d  = 1'b0;
      held_d  = held_q;
      case (state_q)
        REL: begin
          if (acc_press) begin
            state_d = PRESS;
            hold_d  = '0;
          end
        end
        PRESS: begin
          if (acc_release) begin
            state_d = REL;
          end else if (hold_q == HOLD_MAX) begin
            state_d = LONG;
            long_d  = 1'b1;
            held_d  = 1'b1;
          end else begin
            hold_d = hold_q + LW'(1);
          end
        end
        LONG: begin
          if (acc_release) begin
            state_d = REL;
            held_d  = 1'b0;
          end
        end
        default: begin
          state_d = REL;
          held_d  = 1'b0;
        end
      endcase
    end

    assign btn_level[i]     = level_q;
    assign btn_press[i]     = press_q;
    assign btn_release[i]   = release_q;
    assign btn_long[i]      = long_q;
    assign btn_long_held[i] = held_q;
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: randomized and directed raw-pin stimulus against a timestamp-based model.
// Expected outputs are queued per clock edge by the driver and popped by an independent monitor.
// Reset behaviour, async reset drop and queue drain are checked directly.
module tb_btn_debounce;

  localparam int NB = 2;
  localparam int DB = 4;
  localparam int LG = 16;
  localparam int OW = 5 * NB;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_press;
  logic [NB-1:0] btn_release;
  logic [NB-1:0] btn_long;
  logic [NB-1:0] btn_long_held;

  int errors = 0;
  int checks = 0;

  logic [OW-1:0] exp_q[$];

  // Model state per channel, in "pressed = 1" terms.
  int m_s1[NB];     // value sampled at the latest edge
  int m_s2[NB];     // value sampled one edge earlier
  int m_lvl[NB];    // accepted level
  int m_run[NB];    // consecutive edges the delayed sample disagreed with the level
  int m_held[NB];   // long press already flagged for this press
  int m_pt[NB];     // edge number at which the current press was accepted
  int edge_no = 0;

  btn_debounce #(
    .N_BTN          (NB),
    .DEBOUNCE_CYCLES(DB),
    .LONG_CYCLES    (LG),
    .ACTIVE_LOW     (1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_raw      (btn_raw),
    .btn_level    (btn_level),
    .btn_press    (btn_press),
    .btn_release  (btn_release),
    .btn_long     (btn_long),
    .btn_long_held(btn_long_held)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Expected outputs right after the next rising edge, given the raw value that edge samples.
  task automatic model_edge(input logic [NB-1:0] raw, input logic in_rst, output logic [OW-1:0] e);
    logic [NB-1:0] lv, pr, rl, lg, hd;
    int seen;
    lv = '0; pr = '0; rl = '0; lg = '0; hd = '0;
    edge_no++;
    for (int c = 0; c < NB; c++) begin
      if (in_rst) begin
        m_s1[c] = 0; m_s2[c] = 0; m_lvl[c] = 0; m_run[c] = 0; m_held[c] = 0; m_pt[c] = 0;
      end else begin
        // the debouncer acts on the value sampled two edges ago
        seen    = m_s2[c];
        m_s2[c] = m_s1[c];
        m_s1[c] = raw[c] ? 0 : 1;
        if (seen != m_lvl[c]) begin
          m_run[c]++;
          if (m_run[c] == DB) begin
            m_lvl[c] = seen;
            m_run[c] = 0;
            if (seen == 1) begin
              pr[c]   = 1'b1;
              m_pt[c] = edge_no;
            end else begin
              rl[c]     = 1'b1;
              m_held[c] = 0;
            end
          end
        end else begin
          m_run[c] = 0;
        end
        if (m_lvl[c] == 1 && m_held[c] == 0 && (edge_no - m_pt[c]) == LG) begin
          lg[c]     = 1'b1;
          m_held[c] = 1;
        end
        lv[c] = (m_lvl[c] != 0);
        hd[c] = (m_held[c] != 0);
      end
    end
    e = {lv, pr, rl, lg, hd};
  endtask

  task automatic step(input logic [NB-1:0] raw, input logic in_rst);
    logic [OW-1:0] e;
    @(negedge clk);
    btn_raw = raw;
    if (in_rst && rst_n) begin
      rst_n = 1'b0;
      #1;
      check("async_reset_drop", {btn_level, btn_press, btn_release, btn_long, btn_long_held}, '0);
    end
    rst_n = !in_rst;
    model_edge(raw, in_rst, e);
    exp_q.push_back(e);
  endtask

  task automatic hold(input logic [NB-1:0] raw, input int n, input logic in_rst);
    for (int k = 0; k < n; k++) step(raw, in_rst);
  endtask

  // Monitor: compares every edge's outputs against the queued expectation.
  initial begin : monitor
    logic [OW-1:0] e;
    logic [OW-1:0] got;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {btn_level, btn_press, btn_release, btn_long, btn_long_held};
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL outputs t=%0t: got lvl/prs/rel/lng/hld=%b expected %b", $time, got, e);
        end
        checks++;
        if ((btn_press & btn_release) != '0) begin
          errors++;
          $display("FAIL press_release_overlap t=%0t: got %b required 00", $time, btn_press & btn_release);
        end
      end
    end
  end

  initial begin : driver
    logic [NB-1:0] r;
    int len;
    rst_n   = 1'b1;
    btn_raw = '1;
    #1 rst_n = 1'b0;
    #1;
    check("reset_outputs", {btn_level, btn_press, btn_release, btn_long, btn_long_held}, '0);
    hold(2'b11, 3, 1'b1);
    hold(2'b11, 4, 1'b0);
    // clean press on ch0, released before long
    hold(2'b10, 10, 1'b0);
    hold(2'b11, 10, 1'b0);
    // bounce: 3 low, 1 high, then steady low
    hold(2'b10, 3, 1'b0);
    hold(2'b11, 1, 1'b0);
    hold(2'b10, 10, 1'b0);
    hold(2'b11, 10, 1'b0);
    // bounce at count DB-2
    hold(2'b10, 2, 1'b0);
    hold(2'b11, 1, 1'b0);
    hold(2'b10, 8, 1'b0);
    hold(2'b11, 10, 1'b0);
    // long press and release
    hold(2'b10, 30, 1'b0);
    hold(2'b11, 10, 1'b0);
    // short press released 3 edges after acceptance
    hold(2'b10, 8, 1'b0);
    hold(2'b11, 10, 1'b0);
    // both channels together, then release only ch1
    hold(2'b00, 10, 1'b0);
    hold(2'b01, 10, 1'b0);
    hold(2'b11, 10, 1'b0);
    // reset in LONG state, button still held across reset release
    hold(2'b10, 25, 1'b0);
    hold(2'b10, 2, 1'b1);
    hold(2'b10, 30, 1'b0);
    hold(2'b11, 10, 1'b0);
    // random segments
    for (int s = 0; s < 150; s++) begin
      r   = NB'($urandom_range(0, 3));
      len = $urandom_range(1, 2 * DB + 2);
      if ($urandom_range(0, 7) == 0) len = LG + $urandom_range(4, 12);
      if ($urandom_range(0, 29) == 0) hold(r, 2, 1'b1);
      hold(r, len, 1'b0);
    end
    hold(2'b11, 10, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
